// File: rtl/ofs_fim_axis_tx_gen_if.sv
// Shared definitions for the AXIS transmit generator.
//   ofs_pcie_ss_cfg_pkg : default AXIS data/user widths of the PCIe subsystem.
//   pcie_ss_axis_if     : AXI-Stream bundle (tvalid, tready, tdata, tkeep, tlast,
//                         tuser_vendor) with source and sink modports.
package ofs_pcie_ss_cfg_pkg;
    parameter int TDATA_WIDTH = 512;
    parameter int TUSER_WIDTH = 10;
endpackage

interface pcie_ss_axis_if #(
    parameter int DATA_W = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int USER_W = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [USER_W-1:0]     tuser_vendor;

    modport source (
        output tvalid, tlast, tdata, tkeep, tuser_vendor,
        input  tready
    );

    modport sink (
        input  tvalid, tlast, tdata, tkeep, tuser_vendor,
        output tready
    );
endinterface

// File: rtl/ofs_fim_axis_tx_gen.sv
// AXI-Stream transmit pattern generator.
// A start pulse in IDLE launches a job of pkt_count packets, each pkt_len beats
// long. Beat k of the job carries the 32-bit word (seed + k) replicated across
// the bus; the last beat of each packet may carry a partial tkeep.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle job request (honoured only in IDLE)
//   pkt_len, pkt_count  beats per packet (0 acts as 1), packets per job
//   last_bytes          valid bytes on each tlast beat (0 = full beat)
//   seed                first data word of the job
//   busy, done          job in progress, one-cycle completion pulse
//   beat_cnt, stall_cnt accepted beats / stalled tvalid cycles
//   axis_m              AXIS source
//
// Build option: define OFS_FIM_AXIS_TX_GEN_STATS_EN to enable the beat/stall
// statistics counters; otherwise both ports read constant zero.
//
// State | meaning
// IDLE  | waiting for start
// SEND  | tvalid high, presenting beats
// GAP   | idle spacing between packets (GAP_CYCLES > 0 only)
// FIN   | job complete, done pulses on exit
module ofs_fim_axis_tx_gen #(
    parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [15:0]                        pkt_len,
    input  logic [15:0]                        pkt_count,
    input  logic [$clog2(TDATA_WIDTH/8)-1:0]   last_bytes,
    input  logic [31:0]                        seed,
    output logic                               busy,
    output logic                               done,
    output logic [31:0]                        beat_cnt,
    output logic [31:0]                        stall_cnt,
    pcie_ss_axis_if.source                     axis_m
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int LB_W   = $clog2(KEEP_W);
    localparam int WORDS  = TDATA_WIDTH / 32;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t                  state;
    logic [15:0]             len_q;
    logic [15:0]             cnt_q;
    logic [LB_W-1:0]         lb_q;
    logic [31:0]             seed_q;
    logic [15:0]             beat_idx;
    logic [15:0]             pkt_idx;
    logic [31:0]             pat_idx;
    logic [GAP_W-1:0]        gap_cnt;
    logic                    tvalid_r;
    logic                    tlast_r;
    logic [TDATA_WIDTH-1:0]  tdata_r;
    logic [KEEP_W-1:0]       tkeep_r;

    logic                    xfer;
    logic                    pkt_final;
    logic                    next_last;
    logic [31:0]             next_pat;

    function automatic logic [TDATA_WIDTH-1:0] rep_word(input logic [31:0] w);
        return {WORDS{w}};
    endfunction

    function automatic logic [KEEP_W-1:0] keep_mask(input logic is_last,
                                                    input logic [LB_W-1:0] lb);
        logic [KEEP_W-1:0] m;
        m = '1;
        if (is_last && lb != '0) begin
            for (int i = 0; i < KEEP_W; i++) begin
                m[i] = (i < int'(lb));
            end
        end
        return m;
    endfunction

    assign xfer      = tvalid_r && axis_m.tready;
    // Comparing against count-1 keeps 65535-packet jobs inside 16 bits.
    assign pkt_final = (pkt_idx == cnt_q - 16'd1);
    assign next_last = (beat_idx + 16'd1 == len_q - 16'd1);
    assign next_pat  = pat_idx + 32'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            lb_q     <= '0;
            seed_q   <= '0;
            beat_idx <= '0;
            pkt_idx  <= '0;
            pat_idx  <= '0;
            gap_cnt  <= '0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= '0;
            tkeep_r  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= (pkt_len == 16'd0) ? 16'd1 : pkt_len;
                        cnt_q    <= pkt_count;
                        lb_q     <= last_bytes;
                        seed_q   <= seed;
                        beat_idx <= '0;
                        pkt_idx  <= '0;
                        pat_idx  <= '0;
                        busy     <= 1'b1;
                        if (pkt_count == 16'd0) begin
                            state <= FIN;
                        end else begin
                            state    <= SEND;
                            tvalid_r <= 1'b1;
                            tdata_r  <= rep_word(seed);
                            tlast_r  <= (pkt_len <= 16'd1);
                            tkeep_r  <= keep_mask(pkt_len <= 16'd1, last_bytes);
                        end
                    end
                end
                SEND: begin
                    // Outputs only advance on a transfer, so they hold while stalled.
                    if (xfer) begin
                        pat_idx <= next_pat;
                        tdata_r <= rep_word(seed_q + next_pat);
                        if (tlast_r) begin
                            beat_idx <= '0;
                            tlast_r  <= (len_q == 16'd1);
                            tkeep_r  <= keep_mask(len_q == 16'd1, lb_q);
                            if (pkt_final) begin
                                state    <= FIN;
                                tvalid_r <= 1'b0;
                                tlast_r  <= 1'b0;
                            end else begin
                                pkt_idx <= pkt_idx + 16'd1;
                                if (GAP_CYCLES > 0) begin
                                    state    <= GAP;
                                    tvalid_r <= 1'b0;
                                    gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
                                end
                            end
                        end else begin
                            beat_idx <= beat_idx + 16'd1;
                            tlast_r  <= next_last;
                            tkeep_r  <= keep_mask(next_last, lb_q);
                        end
                    end
                end
                GAP: begin
                    // Next packet's first beat is already staged on the outputs.
                    if (gap_cnt == '0) begin
                        state    <= SEND;
                        tvalid_r <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign axis_m.tvalid       = tvalid_r;
    assign axis_m.tlast        = tlast_r;
    assign axis_m.tdata        = tdata_r;
    assign axis_m.tkeep        = tkeep_r;
    assign axis_m.tuser_vendor = {TUSER_WIDTH{1'b0}};

`ifdef OFS_FIM_AXIS_TX_GEN_STATS_EN
    logic [31:0] beat_cnt_r;
    logic [31:0] stall_cnt_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else if (state == IDLE && start) begin
            beat_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (xfer && beat_cnt_r != '1) begin
                beat_cnt_r <= beat_cnt_r + 32'd1;
            end
            if (tvalid_r && !axis_m.tready && stall_cnt_r != '1) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign beat_cnt  = beat_cnt_r;
    assign stall_cnt = stall_cnt_r;
`else
    assign beat_cnt  = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ofs_fim_axis_tx_gen.sv
module tb_ofs_fim_axis_tx_gen;

`ifdef OFS_FIM_AXIS_TX_GEN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] pkt_len, pkt_count;
    logic [5:0]  last_bytes;
    logic [31:0] seed;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] beat_cnt_a, stall_cnt_a, beat_cnt_b, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) axis_a ();
    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) axis_b ();

    ofs_fim_axis_tx_gen #(.TDATA_WIDTH(512), .TUSER_WIDTH(10), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pkt_len(pkt_len),
        .pkt_count(pkt_count), .last_bytes(last_bytes), .seed(seed),
        .busy(busy_a), .done(done_a), .beat_cnt(beat_cnt_a),
        .stall_cnt(stall_cnt_a), .axis_m(axis_a)
    );

    ofs_fim_axis_tx_gen #(.TDATA_WIDTH(512), .TUSER_WIDTH(10), .GAP_CYCLES(3)) dut_gap (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pkt_len(pkt_len),
        .pkt_count(pkt_count), .last_bytes(last_bytes), .seed(seed),
        .busy(busy_b), .done(done_b), .beat_cnt(beat_cnt_b),
        .stall_cnt(stall_cnt_b), .axis_m(axis_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (axis_a.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", axis_a.tvalid); end
        checks++; if (axis_a.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", axis_a.tlast); end
        checks++; if (axis_a.tdata !== 512'd0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", axis_a.tdata[31:0]); end
        checks++; if (axis_a.tkeep !== 64'd0) begin errors++; $display("FAIL reset_tkeep: got %h expected 0", axis_a.tkeep); end
        checks++; if (axis_a.tuser_vendor !== 10'd0) begin errors++; $display("FAIL reset_tuser: got %h expected 0", axis_a.tuser_vendor); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy_a, done_a); end
        checks++; if (beat_cnt_a !== 32'd0 || stall_cnt_a !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", beat_cnt_a, stall_cnt_a); end
        checks++; if (axis_b.tvalid !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_gap_dut: got %b%b expected 00", axis_b.tvalid, busy_b); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic        exp_v;
        pkt_len = 16'd4; pkt_count = 16'd2; seed = 32'h100; last_bytes = 6'd0;
        axis_a.tready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            exp_v = (i <= 8);
            w = 32'h100 + 32'(i - 1);
            checks++; if (axis_a.tvalid !== exp_v) begin errors++; $display("FAIL b2b_tvalid c%0d: got %b expected %b", i, axis_a.tvalid, exp_v); end
            if (exp_v) begin
                checks++; if (axis_a.tdata !== {16{w}}) begin errors++; $display("FAIL b2b_tdata c%0d: got %h expected %h", i, axis_a.tdata[31:0], w); end
                checks++; if (axis_a.tlast !== (i == 4 || i == 8)) begin errors++; $display("FAIL b2b_tlast c%0d: got %b expected %b", i, axis_a.tlast, (i == 4 || i == 8)); end
                checks++; if (axis_a.tkeep !== {64{1'b1}}) begin errors++; $display("FAIL b2b_tkeep c%0d: got %h expected all ones", i, axis_a.tkeep); end
            end
            checks++; if (done_a !== (i == 10)) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", i, done_a, (i == 10)); end
            checks++; if (busy_a !== (i <= 9)) begin errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", i, busy_a, (i <= 9)); end
            step();
        end
        checks++; if (beat_cnt_a !== (STATS ? 32'd8 : 32'd0)) begin errors++; $display("FAIL b2b_beat_cnt: got %0d expected %0d", beat_cnt_a, STATS ? 8 : 0); end
        checks++; if (stall_cnt_a !== 32'd0) begin errors++; $display("FAIL b2b_stall_cnt: got %0d expected 0", stall_cnt_a); end
    endtask

    task automatic test_stall();
        int idx, stalls, n;
        logic [31:0] w;
        pkt_len = 16'd3; pkt_count = 16'd1; seed = 32'h2000; last_bytes = 6'd0;
        axis_a.tready = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        idx = 0; stalls = 0; n = 0;
        while (idx < 3 && n < 20) begin
            axis_a.tready = n[0];
            w = 32'h2000 + 32'(idx);
            checks++; if (axis_a.tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid n%0d: got %b expected 1", n, axis_a.tvalid); end
            checks++; if (axis_a.tdata !== {16{w}}) begin errors++; $display("FAIL stall_tdata n%0d: got %h expected %h", n, axis_a.tdata[31:0], w); end
            checks++; if (axis_a.tlast !== (idx == 2)) begin errors++; $display("FAIL stall_tlast n%0d: got %b expected %b", n, axis_a.tlast, (idx == 2)); end
            if (axis_a.tready) idx++; else stalls++;
            step();
            n++;
        end
        axis_a.tready = 1'b1;
        checks++; if (idx !== 3) begin errors++; $display("FAIL stall_transfers: got %0d expected 3", idx); end
        n = 0;
        while (done_a !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL stall_done_timeout: got %b expected 1", done_a); end
        step();
        step();
        checks++; if (beat_cnt_a !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL stall_beat_cnt: got %0d expected %0d", beat_cnt_a, STATS ? 3 : 0); end
        checks++; if (stall_cnt_a !== (STATS ? 32'(stalls) : 32'd0)) begin errors++; $display("FAIL stall_stall_cnt: got %0d expected %0d", stall_cnt_a, STATS ? stalls : 0); end
    endtask

    task automatic test_tkeep();
        pkt_len = 16'd2; pkt_count = 16'd1; seed = 32'h7000; last_bytes = 6'd5;
        axis_a.tready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (axis_a.tlast !== 1'b0 || axis_a.tkeep !== {64{1'b1}}) begin errors++; $display("FAIL tkeep_first: got tlast=%b tkeep=%h expected 0/all ones", axis_a.tlast, axis_a.tkeep); end
        step();
        checks++; if (axis_a.tlast !== 1'b1 || axis_a.tkeep !== 64'h1F) begin errors++; $display("FAIL tkeep_last: got tlast=%b tkeep=%h expected 1/1f", axis_a.tlast, axis_a.tkeep); end
        checks++; if (axis_a.tdata !== {16{32'h7001}}) begin errors++; $display("FAIL tkeep_data: got %h expected 7001", axis_a.tdata[31:0]); end
        step();
        step();
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL tkeep_done: got %b expected 1", done_a); end
        step();
        // pkt_len = 0 behaves as a single-beat packet
        pkt_len = 16'd0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (axis_a.tvalid !== 1'b1 || axis_a.tlast !== 1'b1 || axis_a.tkeep !== 64'h1F) begin errors++; $display("FAIL len0_beat: got v=%b l=%b k=%h expected 1/1/1f", axis_a.tvalid, axis_a.tlast, axis_a.tkeep); end
        step();
        checks++; if (axis_a.tvalid !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL len0_fin: got v=%b busy=%b expected 0/1", axis_a.tvalid, busy_a); end
        step();
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done_a); end
        step();
    endtask

    task automatic test_gap();
        logic exp_v;
        int   zeros;
        pkt_len = 16'd1; pkt_count = 16'd2; seed = 32'h55; last_bytes = 6'd0;
        axis_b.tready = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        zeros = 0;
        for (int i = 1; i <= 7; i++) begin
            exp_v = (i == 1 || i == 5);
            checks++; if (axis_b.tvalid !== exp_v) begin errors++; $display("FAIL gap_tvalid c%0d: got %b expected %b", i, axis_b.tvalid, exp_v); end
            if (i == 1) begin
                checks++; if (axis_b.tdata !== {16{32'h55}}) begin errors++; $display("FAIL gap_data0: got %h expected 55", axis_b.tdata[31:0]); end
            end
            if (i == 5) begin
                checks++; if (axis_b.tdata !== {16{32'h56}} || axis_b.tlast !== 1'b1) begin errors++; $display("FAIL gap_data1: got %h/%b expected 56/1", axis_b.tdata[31:0], axis_b.tlast); end
            end
            if (i >= 2 && i <= 4 && axis_b.tvalid === 1'b0 && busy_b === 1'b1) zeros++;
            checks++; if (done_b !== (i == 7)) begin errors++; $display("FAIL gap_done c%0d: got %b expected %b", i, done_b, (i == 7)); end
            step();
        end
        checks++; if (zeros !== 3) begin errors++; $display("FAIL gap_idle_cycles: got %0d expected 3", zeros); end
    endtask

    task automatic test_zero_and_busy_start();
        pkt_len = 16'd4; pkt_count = 16'd0; seed = 32'h9; last_bytes = 6'd0;
        axis_a.tready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (axis_a.tvalid !== 1'b0 || busy_a !== 1'b1 || done_a !== 1'b0) begin errors++; $display("FAIL zero_c1: got v=%b b=%b d=%b expected 0/1/0", axis_a.tvalid, busy_a, done_a); end
        step();
        checks++; if (axis_a.tvalid !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL zero_c2: got v=%b d=%b b=%b expected 0/1/0", axis_a.tvalid, done_a, busy_a); end
        step();
        // start while busy must not re-capture
        pkt_len = 16'd2; pkt_count = 16'd1; seed = 32'h300;
        axis_a.tready = 1'b0;
        start_a = 1'b1;
        step();
        pkt_len = 16'd5; pkt_count = 16'd3; seed = 32'h999;
        step();
        start_a = 1'b0;
        axis_a.tready = 1'b1;
        checks++; if (axis_a.tdata !== {16{32'h300}} || axis_a.tlast !== 1'b0) begin errors++; $display("FAIL busy_start_beat0: got %h/%b expected 300/0", axis_a.tdata[31:0], axis_a.tlast); end
        step();
        checks++; if (axis_a.tdata !== {16{32'h301}} || axis_a.tlast !== 1'b1) begin errors++; $display("FAIL busy_start_beat1: got %h/%b expected 301/1", axis_a.tdata[31:0], axis_a.tlast); end
        step();
        checks++; if (axis_a.tvalid !== 1'b0) begin errors++; $display("FAIL busy_start_fin: got %b expected 0", axis_a.tvalid); end
        step();
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %b expected 1", done_a); end
        step();
        checks++; if (busy_a !== 1'b0 || axis_a.tvalid !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got b=%b v=%b expected 0/0", busy_a, axis_a.tvalid); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen_done;
        pkt_len = 16'd4; pkt_count = 16'd1; seed = 32'h400; last_bytes = 6'd0;
        axis_a.tready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        axis_a.tready = 1'b0;
        checks++; if (axis_a.tvalid !== 1'b1 || axis_a.tdata !== {16{32'h401}}) begin errors++; $display("FAIL rstmid_pre: got v=%b d=%h expected 1/401", axis_a.tvalid, axis_a.tdata[31:0]); end
        rst_n = 1'b0;
        step();
        checks++; if (axis_a.tvalid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got v=%b b=%b d=%b expected 0/0/0", axis_a.tvalid, busy_a, done_a); end
        checks++; if (beat_cnt_a !== 32'd0 || axis_a.tdata !== 512'd0) begin errors++; $display("FAIL rstmid_clear: got cnt=%0d d=%h expected 0/0", beat_cnt_a, axis_a.tdata[31:0]); end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        rst_n = 1'b1;
        axis_a.tready = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done_a === 1'b1 || busy_a === 1'b1) seen_done = 1'b1;
            step();
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume: got %b expected 0", seen_done); end
        pkt_len = 16'd1; seed = 32'h500;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (axis_a.tvalid !== 1'b1 || axis_a.tdata !== {16{32'h500}}) begin errors++; $display("FAIL rstmid_restart: got v=%b d=%h expected 1/500", axis_a.tvalid, axis_a.tdata[31:0]); end
        n = 0;
        while (done_a !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rstmid_done_timeout: got %b expected 1", done_a); end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        pkt_len = '0;
        pkt_count = '0;
        last_bytes = '0;
        seed = '0;
        axis_a.tready = 1'b1;
        axis_b.tready = 1'b1;
        test_reset();
        test_back_to_back();
        test_stall();
        test_tkeep();
        test_gap();
        test_zero_and_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofs_fim_axis_tx_gen.md
OFS_FIM_AXIS_TX_GEN -- requirements
Module: ofs_fim_axis_tx_gen

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default ofs_pcie_ss_cfg_pkg::TDATA_WIDTH, AXIS data width; multiple of 32.
REQ-002 The block SHALL have parameter TUSER_WIDTH, default ofs_pcie_ss_cfg_pkg::TUSER_WIDTH, width of tuser_vendor.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 0, idle cycles inserted between packets.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, a one-cycle request to begin a transmit job.
REQ-007 The block SHALL have port pkt_len, input, 16, beats per packet, sampled on accepted start.
REQ-008 The block SHALL have port pkt_count, input, 16, packets per job, sampled on accepted start.
REQ-009 The block SHALL have port last_bytes, input, $clog2(TDATA_WIDTH/8), valid bytes on the last beat (0 = full beat), sampled on accepted start.
REQ-010 The block SHALL have port seed, input, 32, data pattern seed, sampled on accepted start.
REQ-011 The block SHALL have port busy, output, 1, asserted while a job is in progress.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse at job completion.
REQ-013 The block SHALL have port axis_m, pcie_ss_axis_if.source: tvalid, tready, tdata, tkeep, tlast, tuser_vendor.
REQ-014 The block SHALL have ports beat_cnt (output, 32, accepted beats) and stall_cnt (output, 32, cycles with tvalid=1 and tready=0); see Configuration.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP and FIN.
REQ-016 In IDLE, start=1 SHALL be accepted: capture the inputs, zero the beat/packet counters and the pattern index, and enter SEND next cycle; the first tvalid appears 1 cycle after start.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 pkt_count=0 on start SHALL go IDLE->FIN with no beats sent; pkt_len=0 SHALL be treated as 1.
REQ-019 In SEND, tvalid SHALL be 1, and a beat SHALL transfer only on a cycle with tvalid=1 and tready=1.
REQ-020 While tready=0, tdata/tkeep/tlast/tuser_vendor SHALL hold stable.
REQ-021 Back-to-back transfers SHALL be supported: one beat per cycle while tready=1, with no bubbles inside a packet.
REQ-022 The tdata of beat k SHALL be the 32-bit word (seed + k) replicated across TDATA_WIDTH; k counts from 0 across the whole job and wraps modulo 2^32.
REQ-023 tlast SHALL be 1 on beat pkt_len-1 of each packet.
REQ-024 tkeep SHALL be all-ones except on tlast beats with last_bytes!=0, where bits [last_bytes-1:0] are 1 and the rest are 0.
REQ-025 tuser_vendor SHALL be 0.
REQ-026 After a transfer with tlast: if the packet counter reaches pkt_count, go to FIN; else go to GAP when GAP_CYCLES>0, otherwise stay in SEND (next packet follows the next cycle).
REQ-027 GAP SHALL hold tvalid=0 for exactly GAP_CYCLES cycles, then return to SEND.
REQ-028 FIN SHALL assert done for 1 cycle, then go to IDLE.
REQ-029 busy SHALL be 1 in SEND, GAP and FIN, and 0 in IDLE.
REQ-030 The counters SHALL be 16-bit and compare against the captured values, so pkt_len=65535 and pkt_count=65535 complete without overflow.

Reset
REQ-031 rst_n=0 SHALL force, at the next edge: state=IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, done=0, and all counters (including beat_cnt and stall_cnt) =0.
REQ-032 Reset mid-packet SHALL abort the job with no resumption and no done pulse; tvalid SHALL drop even if tready=0.
REQ-033 start SHALL be ignored while rst_n=0.

Configuration
REQ-034 With macro OFS_FIM_AXIS_TX_GEN_STATS_EN defined, beat_cnt SHALL increment per accepted beat and stall_cnt per stalled tvalid cycle; both clear on accepted start, saturate at 2^32-1, and persist after done.
REQ-035 Without OFS_FIM_AXIS_TX_GEN_STATS_EN, beat_cnt and stall_cnt SHALL be tied to 0, no counter logic SHALL be present, and the ports SHALL remain.

Verification
REQ-036 The bench SHALL cover: start with pkt_len=4, pkt_count=2, seed=0x100, last_bytes=0, GAP_CYCLES=0, tready=1 -> 8 consecutive beats with data 0x100..0x107, tlast on beats 3 and 7, done 10 cycles after start.
REQ-037 The bench SHALL cover: tready toggling 1/0 every cycle with pkt_len=3, pkt_count=1 -> data held during stalls, 3 transfers; with STATS_EN, beat_cnt=3 and stall_cnt equal to the stalled cycles.
REQ-038 The bench SHALL cover: TDATA_WIDTH=512, last_bytes=5, pkt_len=1 -> tkeep=64'h1F with tlast=1; non-last beats all-ones.
REQ-039 The bench SHALL cover: GAP_CYCLES=3, pkt_count=2, pkt_len=1 -> exactly 3 tvalid=0 cycles between the two beats.
REQ-040 The bench SHALL cover: pkt_count=0 -> no tvalid, done 2 cycles after start; start while busy -> ignored, captured values unchanged.
REQ-041 The bench SHALL cover: rst_n=0 asserted mid-packet while tready=0 -> tvalid=0 and busy=0 next edge, no done; a new start after release restarts at data=seed.
